// File: rtl/uart_rx_if.sv
// Receive-side bus between the CPU port decoder (master) and the UART receiver core (slave).
interface uart_rx_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PRESCALE_W = 20
);
    logic [PRESCALE_W-1:0] prescale;
    logic                  rx;
    logic                  rd;
    logic [DATA_BITS-1:0]  data_out;
    logic                  data_valid;
    logic                  frame_err;
    logic                  overrun;
    logic                  busy;

    modport master (
        output prescale, rx, rd,
        input  data_out, data_valid, frame_err, overrun, busy
    );

    modport slave (
        input  prescale, rx, rd,
        output data_out, data_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// 16x oversampling 8N1 UART receiver holding one byte for the CPU, with sticky framing/overrun flags.
module uart_rx_core #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PRESCALE_W = 20,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  rx_meta;
    logic                  rx_s;
    logic [PRESCALE_W-1:0] presc_cnt;
    logic                  tick;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  start_det;
    logic                  start_ok;
    logic                  bit_sample;
    logic                  stop_sample;

    logic [DATA_BITS-1:0]  data_out;
    logic                  data_valid;
    logic                  frame_err;
    logic                  overrun;
    logic                  busy;

    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.frame_err  = frame_err;
    assign bus.overrun    = overrun;
    assign bus.busy       = busy;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // Tick generator: held loaded while idle so the first tick lands prescale+1 clocks after start.
    assign tick = (state != IDLE) && (presc_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if ((state == IDLE) || tick) begin
            presc_cnt <= bus.prescale;
        end else begin
            presc_cnt <= presc_cnt - PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_det   = 1'b0;
        start_ok    = 1'b0;
        bit_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    start_det  = 1'b1;
                end
            end
            START: begin
                if (tick && (tick_cnt == HALF_LAST)) begin
                    if (!rx_s) begin
                        state_next = DATA;
                        start_ok   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick && (tick_cnt == FULL_LAST)) begin
                    bit_sample = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (tick && (tick_cnt == FULL_LAST)) begin
                    stop_sample = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit-timing counters and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (start_det || start_ok) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            if (start_ok) begin
                bit_cnt <= '0;
            end else if (bit_sample) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (bit_sample) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
        end
    end

    // CPU-visible holding register; a completing byte takes priority over a simultaneous read.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            if (stop_sample && rx_s) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                overrun    <= bus.rd ? 1'b0 : (overrun | data_valid);
                frame_err  <= bus.rd ? 1'b0 : frame_err;
            end else if (stop_sample) begin
                frame_err <= 1'b1;
                if (bus.rd) begin
                    data_valid <= 1'b0;
                    overrun    <= 1'b0;
                end
            end else if (bus.rd) begin
                data_valid <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end
endmodule
